alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit aluControl code produced by the ALU control decoder. It is the receiving end of that code interface.
- Performs the selected LEGv8 operation on two operands and registers the result with flags and a branch decision.
- Input and output use valid/ready handshakes. A 2-entry output buffer (main + skid) absorbs downstream back-pressure without losing or duplicating operations.
- Sits between the register-read stage and the memory/writeback stage.

---
 rtl/alu_exec_unit.sv | 101 ++++++++++
 tb/tb_alu_exec_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: LEGv8 execute-stage ALU with valid/ready handshakes and a main+skid output buffer
module alu_exec_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       mov_hw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             branch_taken,
    output logic             illegal_op
);
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
        logic             br;
        logic             ill;
    } op_t;

    op_t              nxt, main_q, skid_q;
    logic             main_v, skid_v, acc, sub, cout;
    logic [WIDTH-1:0] bb, sum, mv;
    logic [1:0]       hw;

    // ADD and SUB share one adder; SUB feeds ~B with carry-in 1
    assign sub          = alu_control == 4'b1010;
    assign bb           = sub ? ~operand_b : operand_b;
    assign {cout, sum}  = {1'b0, operand_a} + {1'b0, bb} + (WIDTH+1)'(sub);
    assign hw           = WIDTH == 32 ? {1'b0, mov_hw[0]} : mov_hw;
    assign mv           = WIDTH'(operand_b[15:0]) << {hw, 4'b0000};

    always_comb begin
        nxt = '0;
        case (alu_control)
            4'b0010, 4'b1010: begin
                nxt.res = sum;
                nxt.c   = cout;
                nxt.v   = (operand_a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            4'b0110: nxt.res = operand_a & operand_b;
            4'b0100: nxt.res = operand_a | operand_b;
            4'b1001: nxt.res = operand_a ^ operand_b;
            4'b0111: begin
                nxt.res = operand_b;
                nxt.br  = operand_b == '0;
            end
            4'b1111: begin
                nxt.res = operand_b;
                nxt.br  = operand_b != '0;
            end
            4'b1101: nxt.res = mv;
            default: nxt.ill = 1'b1;
        endcase
        nxt.n = nxt.res[WIDTH-1];
        nxt.z = !nxt.ill && nxt.res == '0;
    end

    assign acc = in_valid && in_ready;

    // main reloads from the input when empty or draining with skid empty; skid only fills under stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            if (acc && (!main_v || out_ready))
                main_q <= nxt;
            else if (main_v && out_ready && skid_v)
                main_q <= skid_q;
            if (acc && main_v && !out_ready)
                skid_q <= nxt;
            main_v <= acc || skid_v || (main_v && !out_ready);
            skid_v <= skid_v ? !out_ready : (acc && main_v && !out_ready);
        end
    end

    assign in_ready     = !skid_v;
    assign out_valid    = main_v;
    assign result       = main_q.res;
    assign flag_n       = main_q.n;
    assign flag_z       = main_q.z;
    assign flag_c       = main_q.c;
    assign flag_v       = main_q.v;
    assign branch_taken = main_q.br;
    assign illegal_op   = main_q.ill;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit with an ADD scoreboard for streaming
module tb_alu_exec_unit;
    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [3:0]  alu_control = 0;
    logic [63:0] operand_a = 0;
    logic [63:0] operand_b = 0;
    logic [1:0]  mov_hw = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] result;
    logic        flag_n, flag_z, flag_c, flag_v, branch_taken, illegal_op;

    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    bit          mon_en = 0;
    bit          stall_prev = 0;
    logic [63:0] held;
    logic [63:0] q[$];

    alu_exec_unit #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
        .mov_hw(mov_hw), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .branch_taken(branch_taken), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: every accepted ADD must emerge once, in order, and hold while stalled
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev)
                chk("hold", result, held);
            if (out_valid && out_ready) begin
                chk("underflow", 64'(q.size() == 0), 0);
                if (q.size() != 0)
                    chk("order", result, q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready)
                q.push_back(operand_a + operand_b);
            stall_prev = out_valid && !out_ready;
            held = result;
        end
    end

    task automatic do_op(input string tag, input logic [3:0] code, input logic [63:0] a,
                         input logic [63:0] b, input logic [1:0] hw,
                         input logic [63:0] exp_r, input logic [5:0] exp_f);
        alu_control = code;
        operand_a = a;
        operand_b = b;
        mov_hw = hw;
        in_valid = 1;
        out_ready = 1;
        @(posedge clk);
        #1 in_valid = 0;
        chk({tag, "_res"}, result, exp_r);
        chk({tag, "_flg"}, {out_valid, flag_n, flag_z, flag_c, flag_v, branch_taken, illegal_op},
            {1'b1, exp_f});
    endtask

    task automatic stream(input int n, input bit rnd);
        int  sent = 0;
        int  base = n_out;
        int  guard = 0;
        bit  a;
        alu_control = 4'b0010;
        operand_a = {$urandom, $urandom};
        operand_b = {$urandom, $urandom};
        in_valid = 1;
        while ((sent < n || n_out - base < n) && guard < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            a = in_valid && in_ready;
            if (!rnd && sent >= 1 && n_out - base < n)
                chk("tput", 64'(out_valid), 1);
            @(posedge clk);
            #1;
            if (a) begin
                sent++;
                operand_a = {$urandom, $urandom};
                operand_b = {$urandom, $urandom};
                if (sent == n)
                    in_valid = 0;
            end
            guard++;
        end
        chk("drain", 64'(n_out - base), 64'(n));
    endtask

    initial begin
        int  idx;
        int  base;
        int  guard;
        bit  a;
        #12;
        chk("rst_state", {out_valid, result, flag_n, flag_z, flag_c, flag_v, branch_taken, illegal_op}, 0);
        @(posedge clk);
        #1 reset = 0;
        @(posedge clk);
        #1 chk("rst_ready", 64'(in_ready), 1);

        do_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 6'b100100);
        do_op("add_carry", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 6'b011000);
        do_op("sub_eq", 4'b1010, 64'd5, 64'd5, 0, 64'd0, 6'b011000);
        do_op("sub_borrow", 4'b1010, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 6'b100000);
        do_op("sub_ovf", 4'b1010, 64'h8000_0000_0000_0000, 64'd1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 6'b001100);
        do_op("and", 4'b0110, 64'hF0F0, 64'h0FF0, 0, 64'h00F0, 6'b000000);
        do_op("orr", 4'b0100, 64'hF0F0, 64'h0FF0, 0, 64'hFFF0, 6'b000000);
        do_op("eor", 4'b1001, 64'hF0F0, 64'h0FF0, 0, 64'hFF00, 6'b000000);
        do_op("mov2", 4'b1101, 64'h1234, 64'hFFFF_0000_0000_BEEF, 2, 64'h0000_BEEF_0000_0000, 6'b000000);
        do_op("mov3", 4'b1101, 0, 64'h8001, 3, 64'h8001_0000_0000_0000, 6'b100000);
        do_op("cbz_t", 4'b0111, 64'd9, 64'd0, 0, 64'd0, 6'b010010);
        do_op("cbz_nt", 4'b0111, 64'd9, 64'd7, 0, 64'd7, 6'b000000);
        do_op("cbnz_t", 4'b1111, 64'd9, 64'd7, 0, 64'd7, 6'b000010);
        do_op("ill0", 4'b0000, 64'd3, 64'd4, 0, 64'd0, 6'b000001);
        do_op("ill3", 4'b0011, 64'd3, 64'd4, 0, 64'd0, 6'b000001);
        @(posedge clk);
        #1 chk("idle", 64'(out_valid), 0);

        // back-pressure: 4 stalled cycles accept exactly main + skid
        mon_en = 1;
        base = n_out;
        idx = 0;
        alu_control = 4'b0010;
        operand_a = 64'd0;
        operand_b = 64'd100;
        in_valid = 1;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                idx++;
                operand_a = 64'(idx);
            end
        end
        chk("bp_acc", 64'(idx), 2);
        chk("bp_ready", 64'(in_ready), 0);
        out_ready = 1;
        guard = 0;
        while (n_out - base < 6 && guard < 100) begin
            @(negedge clk);
            a = in_valid && in_ready;
            if (n_out - base < 6)
                chk("bp_gap", 64'(out_valid), 1);
            @(posedge clk);
            #1;
            if (a) begin
                idx++;
                operand_a = 64'(idx);
                if (idx == 6)
                    in_valid = 0;
            end
            guard++;
        end
        chk("bp_count", 64'(n_out - base), 6);

        stream(20, 0);
        stream(40, 1);
        chk("sb_empty", 64'(q.size()), 0);

        // reset with both entries full discards them
        mon_en = 0;
        out_ready = 0;
        in_valid = 1;
        alu_control = 4'b0100;
        operand_a = 64'h55;
        operand_b = 64'hAA00;
        repeat (3) @(posedge clk);
        #1 chk("full_ready", 64'(in_ready), 0);
        #2 reset = 1;
        #1 chk("rst_mid", {out_valid, result, flag_n, flag_z, flag_c, flag_v, branch_taken, illegal_op}, 0);
        in_valid = 0;
        @(posedge clk);
        #1 reset = 0;
        @(posedge clk);
        #1 chk("rst_mid_ready", 64'(in_ready), 1);
        out_ready = 1;
        @(posedge clk);
        #1 chk("rst_flushed", 64'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
